// File: rtl/store_buffer_if.sv
// Store buffer bus: MEM-stage store/load-check signals and byte-wide drain port.
// The DUT takes the slave modport; the MEM stage/controller side takes master.
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_length;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_length;
  logic        ld_conflict;
  logic        empty;
  logic        mem_write;
  logic [31:0] mem_w_addr;
  logic [7:0]  mem_w_data;
  logic        mem_w_success;

  modport slave (
    input  st_valid, st_addr, st_data, st_length, ld_addr, ld_length, mem_w_success,
    output st_ready, ld_conflict, empty, mem_write, mem_w_addr, mem_w_data
  );
  modport master (
    output st_valid, st_addr, st_data, st_length, ld_addr, ld_length, mem_w_success,
    input  st_ready, ld_conflict, empty, mem_write, mem_w_addr, mem_w_data
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-store FIFO draining one byte per granted cycle, with per-entry
// load-overlap hazard detection.
module sb_hazard (
  input  logic        valid,
  input  logic        is_head,
  input  logic [31:0] addr,
  input  logic [2:0]  length,
  input  logic [1:0]  byte_idx,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_length,
  output logic        hit
);
  logic [32:0] e_lo, e_hi, l_lo, l_hi;

  // 33-bit sums: ranges never wrap across 2^32
  assign e_lo = {1'b0, addr} + (is_head ? {31'd0, byte_idx} : 33'd0);
  assign e_hi = {1'b0, addr} + {30'd0, length};
  assign l_lo = {1'b0, ld_addr};
  assign l_hi = l_lo + {30'd0, ld_length};
  assign hit  = valid && (l_lo < e_hi) && (e_lo < l_hi);
endmodule

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][31:0]     addr_q;
  logic [DEPTH-1:0][3:0][7:0] data_q;
  logic [DEPTH-1:0][2:0]      len_q;
  logic [PW-1:0]              head, tail;
  logic [CW-1:0]              count;
  logic [1:0]                 byte_idx;
  logic                       push, pop, busy, grant;
  logic [DEPTH-1:0]           hit;

  assign busy            = count != '0;
  assign bus.st_ready    = count != CW'(DEPTH);
  assign bus.empty       = !busy;
  assign bus.mem_write   = busy;
  assign bus.mem_w_addr  = addr_q[head] + {30'd0, byte_idx};
  assign bus.mem_w_data  = data_q[head][byte_idx];

  assign push  = bus.st_valid && bus.st_ready;
  assign grant = bus.mem_w_success && busy;
  assign pop   = grant && ({1'b0, byte_idx} == len_q[head] - 3'd1);

  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail] <= bus.st_addr;
      data_q[tail] <= bus.st_data;
      len_q[tail]  <= bus.st_length;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      byte_idx <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (grant) byte_idx <= pop ? 2'd0 : byte_idx + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry i is live when its distance from head is below count
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off = PW'(i) - head;
    sb_hazard u_hz (
      .valid     ({1'b0, off} < count),
      .is_head   (off == '0),
      .addr      (addr_q[i]),
      .length    (len_q[i]),
      .byte_idx  (byte_idx),
      .ld_addr   (bus.ld_addr),
      .ld_length (bus.ld_length),
      .hit       (hit[i])
    );
  end

  assign bus.ld_conflict = (|hit) || (bus.ld_addr[17] && busy);
endmodule
